ascii_hex_parser: RTL and testbench
===================================

ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the output word width; it must be a multiple of 4 and at least 8.
REQ-002 The block SHALL derive MAX_DIGITS = DATA_W/4, the maximum number of hex digits per token.
REQ-003 Port list, clock and reset first:
- clk  input  1  the single clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
REQ-004 Input stream ports:
- in_valid  input  1  ASCII byte present.
- in_data  input  8  ASCII byte.
- in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-005 Output stream ports:
- out_valid  output  1  parsed token present.
- out_data  output  DATA_W  parsed value, right-aligned.
- out_ndigits  output  $clog2(MAX_DIGITS+1)  digits accepted, saturating.
- out_err  output  1  token contained an invalid character or overflowed.
- out_ready  input  1  consumer accepts the token.

Function
REQ-006 The FSM SHALL have three states:
- IDLE: no token in progress.
- ACCUM: token in progress.
- OUT: token held for the consumer.
REQ-007 in_ready SHALL be 1 in IDLE and ACCUM and 0 in OUT.
REQ-008 Accepting a hex digit ('0'-'9', 'A'-'F', 'a'-'f') SHALL:
- set acc <= {acc[DATA_W-5:0], nibble};
- increment the digit count, saturating at MAX_DIGITS;
- enter ACCUM.
REQ-009 Accepting a digit while the count already equals MAX_DIGITS SHALL set err; the shift still occurs, so out_data keeps the last MAX_DIGITS digits.
REQ-010 Terminators are 0x0D, 0x0A, 0x20 and 0x2C. A terminator accepted in ACCUM SHALL move to OUT; one accepted in IDLE SHALL be discarded with no output.
REQ-011 Any other accepted byte SHALL set err and enter ACCUM, leaving acc unchanged.
REQ-012 out_valid SHALL assert in the cycle after the terminator handshake (latency 1) and hold, with out_data/out_ndigits/out_err stable, until out_ready.
REQ-013 The out_valid && out_ready handshake SHALL clear acc, count and err and return the FSM to IDLE in the same edge. The next byte is accepted the following cycle.
REQ-014 out_valid SHALL be 0 in IDLE and ACCUM.

Reset
REQ-015 rst SHALL asynchronously force:
- state to IDLE;
- acc, count and err to 0;
- out_valid to 0, out_data to 0, out_ndigits to 0, out_err to 0.
In IDLE after reset, in_ready is 1.
REQ-016 Reset mid-token or in OUT SHALL discard the token silently; no out_valid is produced.

Configuration
REQ-017 Macro ASCII_HEX_PREFIX_EN:
- Defined: when the token so far is exactly one digit '0', an accepted 'x' or 'X' SHALL clear acc and count without setting err.
- Undefined: 'x'/'X' is an invalid character per REQ-011.

Structure
REQ-018 Package uart_reg_pkg SHALL hold:
- the FSM state enum;
- the terminator character constants (CR, LF, SP, COMMA).
REQ-019 Sub-module ascii2nibble (combinational) SHALL map a byte to {is_hex, nibble[3:0]}; the parser instantiates it once.

Verification
REQ-020 The bench SHALL cover these directed scenarios (DATA_W=32):
- "1A2b\r", out_ready=1 -> one token, out_data=0x00001A2B, out_ndigits=4, out_err=0, out_valid one cycle after '\r'.
- "123456789\n" -> out_data=0x23456789, out_ndigits=8, out_err=1.
- "12G4 " -> out_data=0x00000124, out_ndigits=3, out_err=1.
- "  \r\n" -> no out_valid; in_ready stays 1.
- "FF," with out_ready=0 for 5 cycles -> out_valid held with out_data=0x000000FF and in_ready=0; released on the first out_ready cycle.
- "0xBEEF\r":
  - with ASCII_HEX_PREFIX_EN -> 0x0000BEEF, out_ndigits=4, out_err=0;
  - without it -> out_err=1.
- rst pulse after "AB" -> no output; "5\r" then yields 0x00000005.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// Shared definitions for the ASCII hex token parser: FSM state encoding,
// terminator characters and a terminator classifier.
package uart_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SP    = 8'h20;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF) || (b == CHAR_SP) || (b == CHAR_COMMA);
    endfunction

endpackage

// File: rtl/ascii2nibble.sv
// Combinational ASCII-to-nibble decoder: flags hex digits (either case) and
// returns their 4-bit value.
module ascii2nibble (
    input  logic [7:0] in_byte,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (in_byte >= 8'h30 && in_byte <= 8'h39) begin
            is_hex = 1'b1;
            nibble = in_byte[3:0];
        end else if ((in_byte >= 8'h41 && in_byte <= 8'h46) ||
                     (in_byte >= 8'h61 && in_byte <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            is_hex = 1'b1;
            nibble = in_byte[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// Parses a byte stream of ASCII hex tokens separated by CR/LF/SP/comma into
// right-aligned words. Optional "0x"/"0X" prefix skipping: ASCII_HEX_PREFIX_EN.
module ascii_hex_parser
    import uart_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int MAX_DIGITS = DATA_W / 4,
    localparam int CNT_W = $clog2(MAX_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_ndigits,
    output logic              out_err,
    input  logic              out_ready
);

    // Handshakes: a byte moves on in_valid && in_ready, a token on
    // out_valid && out_ready, both at the rising edge of clk.
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                is_hex;
    logic [3:0]          nibble;
    logic                in_fire;
    logic                prefix_x;

    ascii2nibble u_dec (
        .in_byte (in_data),
        .is_hex  (is_hex),
        .nibble  (nibble)
    );

    assign in_fire = in_valid && in_ready;

`ifdef ASCII_HEX_PREFIX_EN
    // A lone clean '0' followed by x/X is a prefix, not part of the value.
    assign prefix_x = ((in_data == 8'h78) || (in_data == 8'h58)) &&
                      (cnt_q == CNT_W'(1)) && (acc_q == '0) && !err_q;
`else
    assign prefix_x = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (in_fire) begin
                    if (is_hex) begin
                        acc_d   = {acc_q[DATA_W-5:0], nibble};
                        state_d = ST_ACCUM;
                        if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_term(in_data)) begin
                        if (state_q == ST_ACCUM) begin
                            state_d = ST_OUT;
                        end
                    end else if (prefix_x) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The token is held in the accumulator registers while in OUT.
    assign in_ready    = (state_q != ST_OUT);
    assign out_valid   = (state_q == ST_OUT);
    assign out_data    = acc_q;
    assign out_ndigits = cnt_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Self-checking bench for ascii_hex_parser: directed token scenarios plus a
// randomized byte stream checked against a string-level reference model.
module tb_ascii_hex_parser;

    localparam int DATA_W     = 32;
    localparam int MAX_DIGITS = DATA_W / 4;
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
    localparam int W          = DATA_W + CNT_W + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_ndigits;
    logic              out_err;
    logic              out_ready;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [W-1:0] exp_q[$];
    bit          rand_ready_en = 0;

    // reference model state
    logic [DATA_W-1:0] m_val;
    int                m_n;
    logic              m_err;
    bit                m_active;
    string             m_text;

    ascii_hex_parser #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ndigits (out_ndigits),
        .out_err     (out_err),
        .out_ready   (out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_val    = '0;
        m_n      = 0;
        m_err    = 1'b0;
        m_active = 0;
        m_text   = "";
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        model_clear();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        bit done;
        int budget;
        done = 0;
        budget = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 500) begin
                n_cmp++;
                n_mis++;
                $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, budget);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input int nd, input logic e);
        exp_q.push_back({e, CNT_W'(nd), d});
    endtask

    // behavioural model: one accepted character at a time, token text kept as a string
    task automatic model_byte(input logic [7:0] b);
        int nib;
        bit hex;
        hex = 1;
        if (b >= "0" && b <= "9")      nib = int'(b) - int'("0");
        else if (b >= "a" && b <= "f") nib = int'(b) - int'("a") + 10;
        else if (b >= "A" && b <= "F") nib = int'(b) - int'("A") + 10;
        else begin hex = 0; nib = 0; end

        if (hex) begin
            if (m_n == MAX_DIGITS) m_err = 1'b1;
            else m_n++;
            m_val    = m_val * 16 + DATA_W'(nib);
            m_active = 1;
            m_text   = {m_text, $sformatf("%c", b)};
        end else if (b == 8'h0D || b == 8'h0A || b == 8'h20 || b == 8'h2C) begin
            if (m_active) push_exp(m_val, m_n, m_err);
            model_clear();
`ifdef ASCII_HEX_PREFIX_EN
        end else if ((b == 8'h78 || b == 8'h58) && m_text == "0") begin
            m_val  = '0;
            m_n    = 0;
            m_text = "";
`endif
        end else begin
            m_err    = 1'b1;
            m_active = 1;
            m_text   = {m_text, $sformatf("%c", b)};
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_token: got data=%0h nd=%0d err=%0b with nothing expected",
                         out_data, out_ndigits, out_err);
            end else begin
                chk("token", 64'({out_err, out_ndigits, out_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [7:0] b;
        int sel;
        string hexs;
        int budget;
        hexs = "0123456789abcdefABCDEF";
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        model_clear();

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_ndigits", 64'(out_ndigits), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "1A2b\r" with latency check
        out_ready = 1'b1;
        send_str("1A2b");
        @(negedge clk);
        chk("accum_no_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        push_exp(32'h00001A2B, 4, 1'b0);
        send_byte(8'h0D);
        @(negedge clk);
        chk("latency_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;

        // overflow
        push_exp(32'h23456789, 8, 1'b1);
        send_str("123456789\n");
        // invalid character
        push_exp(32'h00000124, 3, 1'b1);
        send_str("12G4 ");

        // terminators only
        send_str("  \r\n");
        @(negedge clk);
        chk("term_only_in_ready", 64'(in_ready), 64'(1));
        chk("term_only_no_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // backpressure hold
        out_ready = 1'b0;
        push_exp(32'h000000FF, 2, 1'b0);
        send_str("FF,");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(out_data), 64'(32'h000000FF));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release_valid", 64'(out_valid), 64'(0));
        chk("release_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // prefix handling
`ifdef ASCII_HEX_PREFIX_EN
        push_exp(32'h0000BEEF, 4, 1'b0);
`else
        push_exp(32'h0000BEEF, 5, 1'b1);
`endif
        send_str("0xBEEF\r");

        // reset mid-token
        send_str("AB");
        do_reset();
        @(negedge clk);
        chk("mid_rst_no_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_exp(32'h00000005, 1, 1'b0);
        send_str("5\r");
        repeat (3) @(posedge clk);
        #1;

        // randomized stream against the reference model
        do_reset();
        rand_ready_en = 1;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 5)       b = hexs[$urandom_range(0, hexs.len() - 1)];
            else if (sel <= 7)  begin
                case ($urandom_range(0, 3))
                    0: b = 8'h0D;
                    1: b = 8'h0A;
                    2: b = 8'h20;
                    default: b = 8'h2C;
                endcase
            end
            else if (sel == 8)  b = ($urandom_range(0, 1) == 0) ? 8'h78 : 8'h58;
            else if (sel == 9)  b = 8'h30;
            else                b = 8'($urandom_range(0, 255));
            model_byte(b);
            send_byte(b);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        model_byte(8'h0D);
        send_byte(8'h0D);
        rand_ready_en = 0;
        #1;
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
